vmsu_mul_arbiter: RTL and testbench
===================================

Name: vmsu_mul_arbiter

Overview:
- Shares one 8-bit multiplier core (vmsu_8bit_top) between NREQ requesters.
- Each requester presents operands over a valid/ready handshake. A round-robin arbiter issues at most one operation per cycle into the fixed-latency multiplier.
- An in-flight tag pipeline tracks each operation. Results return through a credit-protected response FIFO, tagged with the requester id.
- Sits between Logic Analyzer/Wishbone-driven request sources and the multiplier inside the user project area.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width; must satisfy 2^ID_W >= NREQ.
- MUL_LAT, 2, multiplier latency in cycles (>=1), as defined under Behaviour.
- DEPTH, 4, response FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*8  operand A; requester i uses bits [8i+7:8i].
- req_b  in  NREQ*8  operand B; same packing.
- req_ctrl  in  NREQ  per-requester multiplier control bit.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- mul_a  out  8  operand A to multiplier (registered).
- mul_b  out  8  operand B to multiplier (registered).
- mul_ctrl  out  1  control bit to multiplier (registered).
- mul_p  in  16  multiplier product.
- rsp_valid  out  1  response available.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_p  out  16  product.
- rsp_ready  in  1  consumer accept.
- busy  out  1  high when any operation is in flight or the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release):
  - mul_a, mul_b, mul_ctrl = 0.
  - req_ready = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_p = 0.
  - busy = 0.
  - RR pointer = 0; tag pipeline cleared; FIFO empty.
- Credit rule: outstanding = fifo_count + inflight_count, both registered. Issue is allowed only when outstanding < DEPTH. A pop in cycle t does not enable an issue in cycle t; the freed credit is usable from t+1. Consequence: FIFO push never occurs when the FIFO is full.
- Arbitration (combinational within the cycle):
  - If issue is allowed, grant the first i with req_valid[i]=1, searching from the RR pointer upward with wrap-around.
  - req_ready = grant vector. req_ready may depend on req_valid.
  - A handshake is req_valid[i] & req_ready[i].
  - After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer is held.
- Issue: at a handshake edge t, mul_a/mul_b/mul_ctrl load req_a/req_b/req_ctrl of the granted requester, and tag {valid=1, id=i} enters stage 0 of the tag pipeline. With no grant, mul_* hold their previous values and a valid=0 bubble enters the pipeline.
- Multiplier timing: the core presents the product of the operands loaded at edge t on mul_p so that it is stable at edge t+MUL_LAT. The block samples mul_p at edge t+MUL_LAT, when that tag exits the MUL_LAT-stage pipeline, and pushes {id, mul_p} into the FIFO.
- Response latency: rsp_valid rises in the cycle after edge t+MUL_LAT when the FIFO was empty. Back-to-back issues give back-to-back responses in issue order.
- FIFO:
  - rsp_* reflect the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop is legal at any fill level, including full and empty; count is unchanged.
  - rsp_p and rsp_id hold their values while rsp_valid=1 and rsp_ready=0.
  - Pointers wrap modulo DEPTH.
- busy = (inflight_count != 0) | (fifo_count != 0).
- Product arithmetic: none in this block. mul_ctrl (signed/unsigned mode) is passed through unchanged.
- Reset mid-operation: all in-flight tags and FIFO entries are discarded. No response is produced for requests accepted before reset. mul_p is ignored until a new issue.

Test Plan:
- NREQ=4, MUL_LAT=2: only req 2 valid, a=0x0C, b=0x0B, ctrl=0. Required: req_ready[2]=1 in the same cycle; rsp_valid=1 starting MUL_LAT cycles after the handshake cycle with rsp_id=2, rsp_p=0x0084; busy=0 after the pop.
- All four req_valid held high, rsp_ready=1. Required: grants in order 0,1,2,3,0,1 on consecutive cycles; responses return in that same id order with no gaps.
- RR skip: after a grant to 1, only req 3 is valid. Required: req 3 is granted the next cycle and the pointer becomes 0. Then only req 0 and req 3 are valid. Required: grant 0.
- Backpressure: rsp_ready=0, all requests valid. Required: exactly DEPTH=4 handshakes occur, then req_ready=0 everywhere. Pulse rsp_ready for one cycle. Required: exactly one further handshake, one cycle after the pop; the FIFO never overflows.
- Boundary operands: a=0xFF, b=0xFF, ctrl=0 gives rsp_p equal to the model 0xFE01. ctrl=1 gives mul_ctrl=1 at issue, and rsp_p equals the core's signed result 0x0001.
- Assert rst_n with 2 operations in flight and 1 in the FIFO. Required: all outputs reach their reset values immediately, with no response after release. The first new request after release returns the correct product with the pointer starting at 0.

Source files
------------

// File: rtl/vmsu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vmsu_mul_arbiter
// Description : Round-robin sharing of one fixed-latency 8-bit multiplier
//               between NREQ requesters, with a credit-protected response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module vmsu_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*8-1:0]   req_a,
  input  logic [NREQ*8-1:0]   req_b,
  input  logic [NREQ-1:0]     req_ctrl,
  output logic [NREQ-1:0]     req_ready,
  output logic [7:0]          mul_a,
  output logic [7:0]          mul_b,
  output logic                mul_ctrl,
  input  logic [15:0]         mul_p,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [15:0]         rsp_p,
  input  logic                rsp_ready,
  output logic                busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                          r_run;
  logic [ID_W-1:0]               r_ptr;
  logic [7:0]                    r_mul_a;
  logic [7:0]                    r_mul_b;
  logic                          r_mul_ctrl;
  logic [MUL_LAT-1:0]            r_tag_v;
  logic [MUL_LAT-1:0][ID_W-1:0]  r_tag_id;
  logic [CNT_W-1:0]              r_inflight;
  logic [CNT_W-1:0]              r_count;
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [ID_W-1:0]               r_mem_id [DEPTH];
  logic [15:0]                   r_mem_p  [DEPTH];

  logic [CNT_W:0]                w_outstanding;
  logic                          w_can_issue;
  logic [NREQ-1:0]               w_grant;
  logic [ID_W-1:0]               w_gnt_id;
  logic                          w_gnt_any;
  logic [7:0]                    w_sel_a;
  logic [7:0]                    w_sel_b;
  logic                          w_sel_ctrl;
  logic                          w_push;
  logic [ID_W-1:0]               w_push_id;
  logic                          w_pop;

  // Credits cover both FIFO entries and products still inside the multiplier,
  // so every tag leaving the pipeline is guaranteed a free FIFO slot.
  assign w_outstanding = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_can_issue   = r_run && (w_outstanding < (CNT_W+1)'(DEPTH));

  always_comb begin
    w_grant   = '0;
    w_gnt_id  = '0;
    w_gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_can_issue && !w_gnt_any && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'((int'(r_ptr) + k) % NREQ);
        w_grant[(int'(r_ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_ctrl = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a    = req_a[8*i +: 8];
        w_sel_b    = req_b[8*i +: 8];
        w_sel_ctrl = req_ctrl[i];
      end
    end
  end

  assign req_ready = w_grant;
  assign w_push    = r_tag_v[MUL_LAT-1];
  assign w_push_id = r_tag_id[MUL_LAT-1];
  assign w_pop     = rsp_valid && rsp_ready;

  // Issue side: arbiter pointer, operand registers and tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_ptr      <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_ctrl <= 1'b0;
      r_tag_v    <= '0;
      r_tag_id   <= '0;
      r_inflight <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_gnt_any) begin
        r_mul_a    <= w_sel_a;
        r_mul_b    <= w_sel_b;
        r_mul_ctrl <= w_sel_ctrl;
        if (int'(w_gnt_id) == NREQ - 1) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_gnt_id + 1'b1;
        end
      end
      for (int k = MUL_LAT - 1; k >= 1; k--) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
      r_tag_v[0]  <= w_gnt_any;
      r_tag_id[0] <= w_gnt_id;
      case ({w_gnt_any, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Response FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_id[i] <= '0;
        r_mem_p[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_id[r_wr_ptr] <= w_push_id;
        r_mem_p[r_wr_ptr]  <= mul_p;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_ctrl  = r_mul_ctrl;
  assign rsp_valid = (r_count != '0);
  assign rsp_id    = rsp_valid ? r_mem_id[r_rd_ptr] : '0;
  assign rsp_p     = rsp_valid ? r_mem_p[r_rd_ptr]  : '0;
  assign busy      = (r_inflight != '0) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_vmsu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmsu_mul_arbiter
// Description : Self-checking bench with a behavioural multiplier core and a
//               response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmsu_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 2;
  localparam int DEPTH   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*8-1:0]   req_a;
  logic [NREQ*8-1:0]   req_b;
  logic [NREQ-1:0]     req_ctrl;
  logic [NREQ-1:0]     req_ready;
  logic [7:0]          mul_a;
  logic [7:0]          mul_b;
  logic                mul_ctrl;
  logic [15:0]         mul_p;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_p;
  logic                rsp_ready;
  logic                busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  vmsu_mul_arbiter #(
    .NREQ(NREQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ctrl(mul_ctrl), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic c);
    logic [15:0] sa;
    logic [15:0] sb;
    sa = c ? {{8{a[7]}}, a} : {8'h00, a};
    sb = c ? {{8{b[7]}}, b} : {8'h00, b};
    return sa * sb;
  endfunction

  // Behavioural core: product of the operands loaded at edge t is stable at t+MUL_LAT.
  logic [15:0] p_pipe [MUL_LAT-1];
  always @(posedge clk) begin
    p_pipe[0] <= model_mul(mul_a, mul_b, mul_ctrl);
    for (int k = 1; k < MUL_LAT - 1; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mul_p = p_pipe[MUL_LAT-2];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     p;
  } exp_t;

  exp_t q_exp[$];
  exp_t sb_e;
  int   q_gnt[$];
  int   q_gnt_cyc[$];
  int   q_rsp[$];
  int   q_rsp_cyc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      q_exp.delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          q_exp.push_back('{id: ID_W'(i),
                            p: model_mul(req_a[8*i +: 8], req_b[8*i +: 8], req_ctrl[i])});
          q_gnt.push_back(i);
          q_gnt_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_tests++;
        if (q_exp.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got id=%0d p=%h, required no response", rsp_id, rsp_p);
        end else begin
          sb_e = q_exp.pop_front();
          if (rsp_id !== sb_e.id || rsp_p !== sb_e.p) begin
            n_fail++;
            $display("FAIL sb_response: got id=%0d p=%h, required id=%0d p=%h",
                     rsp_id, rsp_p, sb_e.id, sb_e.p);
          end
        end
        q_rsp.push_back(int'(rsp_id));
        q_rsp_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic c);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_ctrl[i]     = c;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    n_tests++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    n_tests++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: rsp_valid=%b, required 1", name, rsp_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if (mul_a !== 8'h00 || mul_b !== 8'h00 || mul_ctrl !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_mul: got a=%h b=%h c=%b, required 0", name, mul_a, mul_b, mul_ctrl);
    end
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s_ready: got %b, required 0000", name, req_ready);
    end
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_p !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s_rsp: got v=%b id=%0d p=%h, required 0/0/0000", name, rsp_valid, rsp_id, rsp_p);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: got %b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_ctrl = '0;
    req_valid = 4'hF;
    repeat (3) tick();
    check_reset_outputs("reset");
    req_valid = '0;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    q_gnt.delete(); q_gnt_cyc.delete(); q_rsp.delete(); q_rsp_cyc.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h10 + 8'(i), 8'h20 + 8'(i), 1'b0);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    repeat (6) tick();
    req_valid = '0;
    wait_idle("b2b");
    n_tests++;
    if (q_gnt.size() != 6 || q_rsp.size() != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d grants %0d responses, required 6 and 6", q_gnt.size(), q_rsp.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (q_gnt[k] != k % NREQ || q_gnt_cyc[k] != q_gnt_cyc[0] + k) begin
          n_fail++;
          $display("FAIL b2b_grant%0d: got id=%0d cyc+%0d, required id=%0d cyc+%0d",
                   k, q_gnt[k], q_gnt_cyc[k] - q_gnt_cyc[0], k % NREQ, k);
        end
        n_tests++;
        if (q_rsp[k] != k % NREQ || q_rsp_cyc[k] != q_rsp_cyc[0] + k) begin
          n_fail++;
          $display("FAIL b2b_rsp%0d: got id=%0d cyc+%0d, required id=%0d cyc+%0d",
                   k, q_rsp[k], q_rsp_cyc[k] - q_rsp_cyc[0], k % NREQ, k);
        end
      end
    end
  endtask

  task automatic test_single();
    int lat = 0;
    rsp_ready = 1'b1;
    set_req(2, 8'h0C, 8'h0B, 1'b0);
    req_valid = 4'b0100;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b, required 0100", req_ready);
    end
    tick();
    req_valid = '0;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat != MUL_LAT || rsp_id !== 2'd2 || rsp_p !== 16'h0084) begin
      n_fail++;
      $display("FAIL single_rsp: got lat=%0d id=%0d p=%h, required lat=%0d id=2 p=0084",
               lat, rsp_id, rsp_p, MUL_LAT);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: got %b after pop, required 0", busy);
    end
  endtask

  task automatic test_rr_skip();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1000;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL rr_skip3: got %b, required 1000", req_ready);
    end
    tick();
    req_valid = 4'b1001;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_wrap0: got %b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    wait_idle("rr");
  endtask

  task automatic test_backpressure();
    int hs = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h31 + 8'(i), 8'h05 + 8'(3*i), 1'b0);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      hs += $countones(req_valid & req_ready);
      tick();
    end
    n_tests++;
    if (hs != DEPTH || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_fill: got %0d handshakes ready=%b, required %0d and 0000", hs, req_ready, DEPTH);
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_pop_same_cycle: got ready=%b, required 0000", req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    #1;
    n_tests++;
    if ($countones(req_ready) != 1) begin
      n_fail++;
      $display("FAIL bp_after_pop: got ready=%b, required one grant", req_ready);
    end
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      hs += $countones(req_valid & req_ready);
      tick();
      #1;
    end
    n_tests++;
    if (hs != 1) begin
      n_fail++;
      $display("FAIL bp_extra: got %0d handshakes, required 1", hs);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("bp");
  endtask

  task automatic test_boundary();
    rsp_ready = 1'b1;
    set_req(0, 8'hFF, 8'hFF, 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_rsp("bnd_u");
    n_tests++;
    if (rsp_p !== 16'hFE01) begin
      n_fail++;
      $display("FAIL bnd_unsigned: got %h, required FE01", rsp_p);
    end
    tick();
    set_req(0, 8'hFF, 8'hFF, 1'b1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    n_tests++;
    if (mul_ctrl !== 1'b1 || mul_a !== 8'hFF || mul_b !== 8'hFF) begin
      n_fail++;
      $display("FAIL bnd_issue: got a=%h b=%h c=%b, required FF FF 1", mul_a, mul_b, mul_ctrl);
    end
    wait_rsp("bnd_s");
    n_tests++;
    if (rsp_p !== 16'h0001) begin
      n_fail++;
      $display("FAIL bnd_signed: got %h, required 0001", rsp_p);
    end
    wait_idle("bnd");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int n    = 0;
    rsp_ready = 1'b0;
    set_req(1, 8'h21, 8'h05, 1'b0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    set_req(2, 8'h22, 8'h06, 1'b0);
    req_valid = 4'b0100;
    tick();
    set_req(3, 8'h23, 8'h07, 1'b0);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'hF;
    n_tests++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_preload: got rsp_valid=%b busy=%b, required 1 1", rsp_valid, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rsp_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_stale: got %0d response cycles, required 0", seen);
    end
    set_req(0, 8'h0D, 8'h07, 1'b0);
    set_req(1, 8'h11, 8'h02, 1'b0);
    set_req(2, 8'h12, 8'h03, 1'b0);
    set_req(3, 8'h13, 8'h04, 1'b0);
    req_valid = 4'hF;
    #1;
    while (req_ready == '0 && n < 10) begin
      tick();
      n++;
    end
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_ptr: got ready=%b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    wait_rsp("mid_new");
    n_tests++;
    if (rsp_id !== 2'd0 || rsp_p !== 16'h005B) begin
      n_fail++;
      $display("FAIL mid_new: got id=%0d p=%h, required id=0 p=005B", rsp_id, rsp_p);
    end
    wait_idle("mid");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_rr_skip();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    repeat (2) tick();
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending, required 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
